demux1x2_reg: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshakes on every channel: the write-side counterpart of the datapath 2:1 select. It takes one producer stream and steers each word to output 1, output 2, or both (broadcast), holding it in a per-output register until that consumer accepts it. It sits between the write-back source and two sinks, for example the register-file write port and the memory/debug store path. It replaces ad-hoc fan-out wires with flow-controlled routing.

---
 rtl/demux1x2_reg.sv | 128 ++++++++++++
 tb/tb_demux1x2_reg.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready on every channel and a one-entry hold per output.
// Optional per-output delivery counters are enabled with DEMUX1X2_STATS_EN.
module demux1x2_reg #(
   parameter int unsigned width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_bcast,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [width-1:0] out1_data,
   output logic             out2_valid,
   input  logic             out2_ready,
`ifdef DEMUX1X2_STATS_EN
   output logic [width-1:0] out2_data,
   output logic [15:0]      stat_cnt1,
   output logic [15:0]      stat_cnt2
`else
   output logic [width-1:0] out2_data
`endif
);

   logic             v1_q, v1_d;
   logic             v2_q, v2_d;
   logic [width-1:0] d1_q, d1_d;
   logic [width-1:0] d2_q, d2_d;

   logic free1, free2;
   logic hs1, hs2;
   logic accept;
   logic load1, load2;

   always_comb begin
      hs1   = v1_q && out1_ready;
      hs2   = v2_q && out2_ready;
      free1 = !v1_q || out1_ready;
      free2 = !v2_q || out2_ready;

      // Broadcast needs both slots at once so a word is never half-written.
      if (in_bcast) begin
         in_ready = free1 && free2;
      end else if (in_sel) begin
         in_ready = free2;
      end else begin
         in_ready = free1;
      end

      accept = in_valid && in_ready;
      load1  = accept && (in_bcast || !in_sel);
      load2  = accept && (in_bcast || in_sel);
   end

   always_comb begin
      v1_d = v1_q;
      d1_d = d1_q;
      v2_d = v2_q;
      d2_d = d2_q;

      // A load wins over a drain in the same cycle; data is left alone on a plain drain.
      if (load1) begin
         v1_d = 1'b1;
         d1_d = in_data;
      end else if (hs1) begin
         v1_d = 1'b0;
      end

      if (load2) begin
         v2_d = 1'b1;
         d2_d = in_data;
      end else if (hs2) begin
         v2_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         d1_q <= d1_d;
         d2_q <= d2_d;
      end
   end

   assign out1_valid = v1_q;
   assign out1_data  = d1_q;
   assign out2_valid = v2_q;
   assign out2_data  = d2_q;

`ifdef DEMUX1X2_STATS_EN
   logic [15:0] cnt1_q, cnt1_d;
   logic [15:0] cnt2_q, cnt2_d;

   // Counters saturate rather than wrap.
   always_comb begin
      cnt1_d = cnt1_q;
      cnt2_d = cnt2_q;
      if (hs1 && (cnt1_q != 16'hFFFF)) begin
         cnt1_d = cnt1_q + 16'd1;
      end
      if (hs2 && (cnt2_q != 16'hFFFF)) begin
         cnt2_d = cnt2_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else begin
         cnt1_q <= cnt1_d;
         cnt2_q <= cnt2_d;
      end
   end

   assign stat_cnt1 = cnt1_q;
   assign stat_cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_demux1x2_reg.sv
// Self-checking bench for demux1x2_reg: directed scenarios plus constrained-random traffic
// checked against a queue-based scoreboard model of the two holding slots.
module tb_demux1x2_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_sel = 1'b0;
   logic        in_bcast = 1'b0;
   logic        out1_valid;
   logic        out1_ready = 1'b0;
   logic [15:0] out1_data;
   logic        out2_valid;
   logic        out2_ready = 1'b0;
   logic [15:0] out2_data;
`ifdef DEMUX1X2_STATS_EN
   logic [15:0] stat_cnt1;
   logic [15:0] stat_cnt2;
`endif

   int total = 0;
   int bad   = 0;

   // Scoreboard: words waiting on each output, last presented data, delivery counts.
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic [15:0] m_d1 = '0;
   logic [15:0] m_d2 = '0;
   int          c1 = 0;
   int          c2 = 0;

   demux1x2_reg #(.width(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_bcast   (in_bcast),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out1_data  (out1_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
`ifdef DEMUX1X2_STATS_EN
      .out2_data  (out2_data),
      .stat_cnt1  (stat_cnt1),
      .stat_cnt2  (stat_cnt2)
`else
      .out2_data  (out2_data)
`endif
   );

   always #5 clk = ~clk;

   function automatic bit exp_ready();
      bit f1, f2;
      f1 = (q1.size() == 0) || out1_ready;
      f2 = (q2.size() == 0) || out2_ready;
      if (in_bcast) return f1 && f2;
      return in_sel ? f2 : f1;
   endfunction

   task automatic model_clear();
      q1.delete();
      q2.delete();
      m_d1 = '0;
      m_d2 = '0;
      c1   = 0;
      c2   = 0;
   endtask

   // Advance one clock, updating the scoreboard from the inputs presented before the edge.
   task automatic step();
      bit          acc, pop1, pop2, ld1, ld2;
      logic [15:0] d;
      acc  = in_valid && exp_ready();
      pop1 = (q1.size() != 0) && out1_ready;
      pop2 = (q2.size() != 0) && out2_ready;
      ld1  = acc && (in_bcast || !in_sel);
      ld2  = acc && (in_bcast || in_sel);
      d    = in_data;
      @(posedge clk);
      if (rst) begin
         model_clear();
      end else begin
         if (pop1) begin
            void'(q1.pop_front());
            if (c1 < 65535) c1++;
         end
         if (pop2) begin
            void'(q2.pop_front());
            if (c2 < 65535) c2++;
         end
         if (ld1) q1.push_back(d);
         if (ld2) q2.push_back(d);
         if (q1.size() != 0) m_d1 = q1[0];
         if (q2.size() != 0) m_d2 = q2[0];
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL reset_v1 got=%b want=0", out1_valid); end
      total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL reset_v2 got=%b want=0", out2_valid); end
      total++; if (out1_data !== 16'h0) begin bad++; $display("FAIL reset_d1 got=%h want=0000", out1_data); end
      total++; if (out2_data !== 16'h0) begin bad++; $display("FAIL reset_d2 got=%h want=0000", out2_data); end
      // A word offered during reset must not load.
      in_valid = 1'b1; in_data = 16'h9999; in_sel = 1'b0;
      step();
      total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL reset_noload got=%b want=0", out1_valid); end
      in_valid = 1'b0;
      rst = 1'b0;
      model_clear();
      step();
   endtask

   task automatic test_route();
      in_valid = 1'b1; in_data = 16'hA5A5; in_sel = 1'b0; in_bcast = 1'b0; out1_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_rdy got=%b want=1", in_ready); end
      total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL route_pre_v1 got=%b want=0", out1_valid); end
      step();
      in_valid = 1'b0;
      total++; if (out1_valid !== 1'b1) begin bad++; $display("FAIL route_v1 got=%b want=1", out1_valid); end
      total++; if (out1_data !== 16'hA5A5) begin bad++; $display("FAIL route_d1 got=%h want=a5a5", out1_data); end
      total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL route_v2 got=%b want=0", out2_valid); end
      step();
      total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL route_drain got=%b want=0", out1_valid); end
   endtask

   task automatic test_back_to_back();
      out2_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h0001;
      step();
      in_data = 16'h0002;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", in_ready); end
      step();
      step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall2 got=%b want=0", in_ready); end
      total++; if (out2_data !== 16'h0001) begin bad++; $display("FAIL bp_hold got=%h want=0001", out2_data); end
      out2_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (out2_valid !== 1'b1) begin bad++; $display("FAIL bp_v2 got=%b want=1", out2_valid); end
      total++; if (out2_data !== 16'h0002) begin bad++; $display("FAIL bp_next got=%h want=0002", out2_data); end
      step();
      total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out2_valid); end
   endtask

   task automatic test_bcast();
      out1_ready = 1'b0; out2_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_bcast = 1'b0; in_data = 16'h5555;
      step();
      in_bcast = 1'b1; in_data = 16'h1234;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bc_stall got=%b want=0", in_ready); end
      step();
      total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL bc_partial got=%b want=0", out2_valid); end
      total++; if (out1_data !== 16'h5555) begin bad++; $display("FAIL bc_hold got=%h want=5555", out1_data); end
      out1_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bc_rdy got=%b want=1", in_ready); end
      step();
      in_valid = 1'b0; in_bcast = 1'b0;
      total++; if (out1_data !== 16'h1234 || out1_valid !== 1'b1) begin bad++; $display("FAIL bc_out1 got=%b/%h want=1/1234", out1_valid, out1_data); end
      total++; if (out2_data !== 16'h1234 || out2_valid !== 1'b1) begin bad++; $display("FAIL bc_out2 got=%b/%h want=1/1234", out2_valid, out2_data); end
   endtask

   task automatic test_drain_load();
      // out1 and out2 both hold 0x1234 here; out2 keeps its word.
      out1_ready = 1'b1; out2_ready = 1'b0;
      in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hBEEF;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dl_rdy got=%b want=1", in_ready); end
      step();
      in_valid = 1'b0; out1_ready = 1'b0;
      total++; if (out1_valid !== 1'b1) begin bad++; $display("FAIL dl_v1 got=%b want=1", out1_valid); end
      total++; if (out1_data !== 16'hBEEF) begin bad++; $display("FAIL dl_d1 got=%h want=beef", out1_data); end
      total++; if (out2_data !== 16'h1234) begin bad++; $display("FAIL dl_d2 got=%h want=1234", out2_data); end
   endtask

   task automatic test_async_reset();
      step();
      total++; if (out1_valid !== 1'b1 || out2_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b%b want=11", out1_valid, out2_valid); end
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      total++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b%b want=00", out1_valid, out2_valid); end
      total++; if (out1_data !== 16'h0 || out2_data !== 16'h0) begin bad++; $display("FAIL ar_data got=%h/%h want=0000/0000", out1_data, out2_data); end
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h3C3C; out2_ready = 1'b0;
      #1;
      total++; if (out2_valid !== 1'b0) begin bad++; $display("FAIL ar_lat0 got=%b want=0", out2_valid); end
      step();
      in_valid = 1'b0;
      total++; if (out2_valid !== 1'b1 || out2_data !== 16'h3C3C) begin bad++; $display("FAIL ar_lat1 got=%b/%h want=1/3c3c", out2_valid, out2_data); end
      out1_ready = 1'b1; out2_ready = 1'b1;
      step();
   endtask

   task automatic test_random();
      bit hold;
      for (int i = 0; i < 400; i++) begin
         hold = in_valid && !exp_ready();
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            in_sel   = 1'($urandom);
            in_bcast = ($urandom_range(0, 3) == 0);
         end
         out1_ready = ($urandom_range(0, 2) != 0);
         out2_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (in_valid) begin
            total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_ready()); end
         end
         total++; if (out1_valid !== (q1.size() != 0)) begin bad++; $display("FAIL rnd_v1 cyc=%0d got=%b want=%b", i, out1_valid, q1.size() != 0); end
         total++; if (out2_valid !== (q2.size() != 0)) begin bad++; $display("FAIL rnd_v2 cyc=%0d got=%b want=%b", i, out2_valid, q2.size() != 0); end
         total++; if (out1_data !== m_d1) begin bad++; $display("FAIL rnd_d1 cyc=%0d got=%h want=%h", i, out1_data, m_d1); end
         total++; if (out2_data !== m_d2) begin bad++; $display("FAIL rnd_d2 cyc=%0d got=%h want=%h", i, out2_data, m_d2); end
`ifdef DEMUX1X2_STATS_EN
         total++; if (stat_cnt1 !== 16'(c1)) begin bad++; $display("FAIL rnd_cnt1 cyc=%0d got=%0d want=%0d", i, stat_cnt1, c1); end
         total++; if (stat_cnt2 !== 16'(c2)) begin bad++; $display("FAIL rnd_cnt2 cyc=%0d got=%0d want=%0d", i, stat_cnt2, c2); end
`endif
         step();
      end
      in_valid = 1'b0; in_bcast = 1'b0;
   endtask

`ifdef DEMUX1X2_STATS_EN
   task automatic test_stats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      out1_ready = 1'b1; out2_ready = 1'b1;
      in_valid = 1'b1; in_sel = 1'b0; in_bcast = 1'b0;
      for (int i = 0; i < 3; i++) begin in_data = 16'(i); step(); end
      in_bcast = 1'b1;
      for (int i = 0; i < 2; i++) begin in_data = 16'(100 + i); step(); end
      in_valid = 1'b0; in_bcast = 1'b0;
      step();
      total++; if (stat_cnt1 !== 16'd5) begin bad++; $display("FAIL st_cnt1 got=%0d want=5", stat_cnt1); end
      total++; if (stat_cnt2 !== 16'd2) begin bad++; $display("FAIL st_cnt2 got=%0d want=2", stat_cnt2); end
      // 65529 more out1 deliveries bring stat_cnt1 to 0xFFFE.
      in_valid = 1'b1;
      for (int i = 0; i < 65529; i++) step();
      in_valid = 1'b0;
      step();
      total++; if (stat_cnt1 !== 16'hFFFE) begin bad++; $display("FAIL st_pre got=%h want=fffe", stat_cnt1); end
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) step();
      in_valid = 1'b0;
      step();
      total++; if (stat_cnt1 !== 16'hFFFF) begin bad++; $display("FAIL st_sat got=%h want=ffff", stat_cnt1); end
      total++; if (stat_cnt2 !== 16'd2) begin bad++; $display("FAIL st_cnt2_keep got=%0d want=2", stat_cnt2); end
   endtask
`endif

   initial begin
      test_reset();
      test_route();
      test_back_to_back();
      test_bcast();
      test_drain_load();
      test_async_reset();
      test_random();
`ifdef DEMUX1X2_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
